// File: rtl/virtio_available_ring_pkg.sv
// Types shared by the available-ring scheduler and the ring monitor/reader.
// Request payload is sized for the largest supported ring (32768 entries).
package virtio_available_ring_pkg;

  typedef enum logic [1:0] {
    REQUEST_READ_RING = 2'd1
  } request_type_t;

  typedef struct packed {
    logic [14:0] offset;
    logic [14:0] length;
  } request_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } scheduler_state_t;

endpackage

// File: rtl/virtio_available_ring_scheduler_if.sv
// AXI4-Stream style request channel used between the scheduler and the ring reader.
interface logic_axi4_stream_if #(
  parameter int DATA_W = 30,
  parameter int ID_W   = 2,
  parameter int DEST_W = 2
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;

  modport master (output tvalid, tdata, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tid, tdest, output tready);
  modport tx     (output tvalid, tdata, tid, tdest, input tready);
  modport rx     (input tvalid, tdata, tid, tdest, output tready);
endinterface

// File: rtl/virtio_available_ring_scheduler_arbiter.sv
// Round-robin arbiter: scans from ptr+1 with wrap; ptr follows the grant on advance.
module virtio_available_ring_scheduler_arbiter #(
  parameter int QUEUES      = 4,
  parameter int QUEUE_WIDTH = $clog2(QUEUES)
) (
  input  logic                   aclk,
  input  logic                   areset_n,
  input  logic [QUEUES-1:0]      request,
  input  logic                   advance,
  output logic                   grant_valid,
  output logic [QUEUE_WIDTH-1:0] grant
);
  logic [QUEUE_WIDTH-1:0] ptr;
  logic [QUEUE_WIDTH-1:0] idx;

  always_comb begin
    grant_valid = 1'b0;
    grant       = ptr;
    idx         = ptr;
    for (int k = 1; k <= QUEUES; k++) begin
      idx = ptr + QUEUE_WIDTH'(k);
      if (!grant_valid && request[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
  end

  // Reset to the last queue so queue 0 wins the first scan.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      ptr <= QUEUE_WIDTH'(QUEUES - 1);
    end else if (advance) begin
      ptr <= grant;
    end
  end
endmodule

// File: rtl/virtio_available_ring_scheduler.sv
// Turns per-queue available-index doorbells into bounded REQUEST_READ_RING chunks.
// Optional per-queue reset: define VIRTIO_AVAILABLE_RING_SCHEDULER_QUEUE_RESET_EN.
module virtio_available_ring_scheduler
  import virtio_available_ring_pkg::*;
#(
  parameter int QUEUES                 = 4,
  parameter int QUEUE_SIZE             = 256,
  parameter int MAX_DESCRIPTOR_INDEXES = 4,
  parameter int QUEUE_WIDTH            = $clog2(QUEUES)
) (
  input  logic                   aclk,
  input  logic                   areset_n,
  input  logic                   notify_valid,
  input  logic [QUEUE_WIDTH-1:0] notify_queue,
  input  logic [15:0]            notify_index,
  output logic                   notify_ready,
`ifdef VIRTIO_AVAILABLE_RING_SCHEDULER_QUEUE_RESET_EN
  input  logic                   queue_reset_valid,
  input  logic [QUEUE_WIDTH-1:0] queue_reset_queue,
`endif
  output logic                   error,
  logic_axi4_stream_if.tx        tx
);
  // state | meaning
  // IDLE  | nothing in flight; arbitrate every cycle
  // ISSUE | tx payload held stable until tready; re-arbitrate on the handshake
  localparam logic [0:0]  ST_IDLE  = IDLE;
  localparam logic [0:0]  ST_ISSUE = ISSUE;
  localparam int          OFF_W    = $clog2(QUEUE_SIZE);
  localparam logic [16:0] QSIZE    = 17'(QUEUE_SIZE);
  localparam logic [16:0] QMAX     = 17'(MAX_DESCRIPTOR_INDEXES);

  logic [15:0]            avail_idx [QUEUES];
  logic [15:0]            last_idx  [QUEUES];
  logic [15:0]            last_eff  [QUEUES];
  logic [15:0]            pend      [QUEUES];
  logic [0:0]             state;
  logic [QUEUE_WIDTH-1:0] cur_q;
  logic                   cur_dropped;
  request_t               tdata_q;
  request_t               req_next;
  logic                   qr_valid;
  logic [QUEUE_WIDTH-1:0] qr_queue;
  logic                   handshake;
  logic                   skip_adv;
  logic                   arb_en;
  logic                   load;
  logic [QUEUES-1:0]      request;
  logic                   grant_valid;
  logic [QUEUE_WIDTH-1:0] grant;
  logic                   notify_fire;
  logic                   notify_ok;
  logic [15:0]            notify_diff;
  logic [15:0]            len_plus1;
  logic [16:0]            chunk;
  logic [16:0]            room;
  logic [OFF_W-1:0]       g_off;

`ifdef VIRTIO_AVAILABLE_RING_SCHEDULER_QUEUE_RESET_EN
  assign qr_valid     = queue_reset_valid;
  assign qr_queue     = queue_reset_queue;
  assign notify_ready = !(queue_reset_valid && (queue_reset_queue == notify_queue));
`else
  assign qr_valid     = 1'b0;
  assign qr_queue     = '0;
  assign notify_ready = 1'b1;
`endif

  assign handshake = (state == ST_ISSUE) && tx.tready;
  // A queue reset seen at any point during ISSUE suppresses the index advance.
  assign skip_adv  = cur_dropped || (qr_valid && (qr_queue == cur_q));
  assign arb_en    = (state == ST_IDLE) || handshake;
  assign load      = arb_en && grant_valid;
  assign len_plus1 = {1'b0, tdata_q.length} + 16'd1;

  // last_eff folds in the completing handshake so re-arbitration sees the remainder.
  always_comb begin
    for (int i = 0; i < QUEUES; i++) begin
      last_eff[i] = last_idx[i];
      if (handshake && !skip_adv && (cur_q == QUEUE_WIDTH'(i))) begin
        last_eff[i] = last_idx[i] + len_plus1;
      end
      pend[i]    = avail_idx[i] - last_eff[i];
      request[i] = (pend[i] != 16'd0) && !(qr_valid && (qr_queue == QUEUE_WIDTH'(i)));
    end
  end

  virtio_available_ring_scheduler_arbiter #(
    .QUEUES      (QUEUES),
    .QUEUE_WIDTH (QUEUE_WIDTH)
  ) u_arbiter (
    .aclk        (aclk),
    .areset_n    (areset_n),
    .request     (request),
    .advance     (load),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Chunk never crosses the ring wrap.
  always_comb begin
    g_off = last_eff[grant][OFF_W-1:0];
    room  = QSIZE - 17'(g_off);
    chunk = {1'b0, pend[grant]};
    if (chunk > QMAX) chunk = QMAX;
    if (chunk > room) chunk = room;
    req_next        = '0;
    req_next.offset = 15'(g_off);
    req_next.length = 15'(chunk - 17'd1);
  end

  assign notify_fire = notify_valid && notify_ready;
  assign notify_diff = notify_index - last_idx[notify_queue];
  assign notify_ok   = ({1'b0, notify_diff} <= QSIZE);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < QUEUES; i++) begin
        avail_idx[i] <= 16'd0;
        last_idx[i]  <= 16'd0;
      end
      error <= 1'b0;
    end else begin
      for (int i = 0; i < QUEUES; i++) begin
        if (qr_valid && (qr_queue == QUEUE_WIDTH'(i))) begin
          avail_idx[i] <= 16'd0;
          last_idx[i]  <= 16'd0;
        end else begin
          last_idx[i] <= last_eff[i];
          if (notify_fire && notify_ok && (notify_queue == QUEUE_WIDTH'(i))) begin
            avail_idx[i] <= notify_index;
          end
        end
      end
      if (notify_fire && !notify_ok) error <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state       <= ST_IDLE;
      cur_q       <= '0;
      cur_dropped <= 1'b0;
      tdata_q     <= '0;
    end else if (load) begin
      state       <= ST_ISSUE;
      cur_q       <= grant;
      cur_dropped <= 1'b0;
      tdata_q     <= req_next;
    end else if (handshake) begin
      state <= ST_IDLE;
    end else if ((state == ST_ISSUE) && qr_valid && (qr_queue == cur_q)) begin
      cur_dropped <= 1'b1;
    end
  end

  assign tx.tvalid = (state == ST_ISSUE);
  assign tx.tdata  = tdata_q;
  assign tx.tdest  = cur_q;
  assign tx.tid    = REQUEST_READ_RING;
endmodule

// File: tb/tb_virtio_available_ring_scheduler.sv
// Scoreboard bench: directed plan cases, then random doorbell batches against a queue-level model.
module tb_virtio_available_ring_scheduler;
  import virtio_available_ring_pkg::*;

  localparam int NQ   = 4;
  localparam int QS   = 256;
  localparam int MAXD = 4;

  typedef struct packed {
    int q;
    int off;
    int len;
  } exp_t;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic        notify_valid;
  logic [1:0]  notify_queue;
  logic [15:0] notify_index;
  logic        notify_ready;
  logic        error;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  bit [15:0] avail_m [NQ];
  bit [15:0] last_m  [NQ];
  int        ptr_m;
  bit        exp_error;

  logic_axi4_stream_if #(.DATA_W($bits(request_t)), .ID_W(2), .DEST_W(2)) tx_if ();

  virtio_available_ring_scheduler #(
    .QUEUES(NQ), .QUEUE_SIZE(QS), .MAX_DESCRIPTOR_INDEXES(MAXD)
  ) dut (
    .aclk         (aclk),
    .areset_n     (areset_n),
    .notify_valid (notify_valid),
    .notify_queue (notify_queue),
    .notify_index (notify_index),
    .notify_ready (notify_ready),
`ifdef VIRTIO_AVAILABLE_RING_SCHEDULER_QUEUE_RESET_EN
    .queue_reset_valid (1'b0),
    .queue_reset_queue (2'd0),
`endif
    .error        (error),
    .tx           (tx_if)
  );

  always #5 aclk = ~aclk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic void push_exp(int q, int off, int len);
    exp_q.push_back('{q: q, off: off, len: len});
  endfunction

  // Reference model: indexes as plain numbers, round-robin scan, min() chunking.
  function automatic void model_reset();
    for (int i = 0; i < NQ; i++) begin
      avail_m[i] = 16'd0;
      last_m[i]  = 16'd0;
    end
    ptr_m     = NQ - 1;
    exp_error = 1'b0;
  endfunction

  function automatic void model_notify(int q, bit [15:0] idx);
    bit [15:0] d;
    d = idx - last_m[q];
    if (int'(d) <= QS) avail_m[q] = idx;
    else exp_error = 1'b1;
  endfunction

  function automatic bit pick(output int q, output int off, output int len);
    bit [15:0] pd;
    int c;
    q = 0; off = 0; len = 0;
    for (int k = 1; k <= NQ; k++) begin
      c  = (ptr_m + k) % NQ;
      pd = avail_m[c] - last_m[c];
      if (pd != 16'd0) begin
        off = int'(last_m[c]) % QS;
        len = int'(pd);
        if (len > MAXD) len = MAXD;
        if (len > QS - off) len = QS - off;
        q = c;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic void commit(int q, int len);
    last_m[q] = last_m[q] + 16'(len);
    ptr_m     = q;
  endfunction

  task automatic doorbell(input int q, input bit [15:0] idx);
    notify_valid = 1'b1;
    notify_queue = 2'(q);
    notify_index = idx;
    @(posedge aclk); #1;
    notify_valid = 1'b0;
  endtask

  task automatic drain(input bit rand_ready);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tx_if.tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge aclk); #1;
      n++;
    end
    tx_if.tready = 1'b1;
    check("drain_leftover", exp_q.size(), 0);
    @(negedge aclk);
    check("idle_tvalid", tx_if.tvalid, 1'b0);
    @(posedge aclk); #1;
  endtask

  // Monitor: pops an expectation on every handshake and checks hold-while-stalled.
  initial begin : monitor
    request_t   r;
    logic       stalled;
    logic [29:0] sv_data;
    logic [1:0]  sv_dest;
    exp_t       e;
    stalled = 1'b0;
    sv_data = '0;
    sv_dest = '0;
    forever begin
      @(negedge aclk);
      if (!areset_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_tvalid", tx_if.tvalid, 1'b1);
          check("hold_tdata", tx_if.tdata, sv_data);
          check("hold_tdest", tx_if.tdest, sv_dest);
        end
        if (tx_if.tvalid) begin
          if (tx_if.tready) begin
            r = request_t'(tx_if.tdata);
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_request actual=q%0d/off%0d/len%0d required=none",
                       tx_if.tdest, r.offset, r.length);
            end else begin
              e = exp_q.pop_front();
              check("req_tdest", tx_if.tdest, e.q);
              check("req_offset", r.offset, e.off);
              check("req_length", r.length, e.len);
              check("req_tid", tx_if.tid, REQUEST_READ_RING);
            end
          end
          stalled = !tx_if.tready;
          sv_data = tx_if.tdata;
          sv_dest = tx_if.tdest;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int fq, foff, flen, q, q2, k;
    bit [15:0] ni;
    areset_n     = 1'b0;
    notify_valid = 1'b0;
    notify_queue = 2'd0;
    notify_index = 16'd0;
    tx_if.tready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_tvalid", tx_if.tvalid, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_notify_ready", notify_ready, 1'b1);
    @(posedge aclk); #1;
    areset_n = 1'b1;
    @(posedge aclk); #1;

    // Single doorbell: latency N+2, then tvalid drops.
    push_exp(0, 0, 2);
    doorbell(0, 16'd3);
    @(negedge aclk); check("lat_n1_tvalid", tx_if.tvalid, 1'b0);
    @(negedge aclk); check("lat_n2_tvalid", tx_if.tvalid, 1'b1);
    @(negedge aclk); check("after_hs_tvalid", tx_if.tvalid, 1'b0);
    check("after_hs_queue", exp_q.size(), 0);
    @(posedge aclk); #1;

    // Split into MAX-sized chunks.
    push_exp(1, 0, 3); push_exp(1, 4, 3); push_exp(1, 8, 1);
    doorbell(1, 16'd10);
    drain(1'b0);

    // Two busy queues interleave.
    push_exp(0, 3, 3); push_exp(2, 0, 3); push_exp(0, 7, 3); push_exp(2, 4, 3);
    doorbell(0, 16'd11);
    doorbell(2, 16'd8);
    drain(1'b0);

    // Ring wrap on q3: drain to 254, then 254..259 splits at the wrap.
    for (int j = 0; j < 63; j++) push_exp(3, 4 * j, 3);
    push_exp(3, 252, 1);
    doorbell(3, 16'd254);
    drain(1'b0);
    push_exp(3, 254, 1); push_exp(3, 0, 3);
    doorbell(3, 16'd260);
    drain(1'b0);

    // Stall with a same-queue doorbell while the payload is held.
    tx_if.tready = 1'b0;
    push_exp(1, 10, 3);
    doorbell(1, 16'd14);
    doorbell(1, 16'd20);
    repeat (5) @(posedge aclk);
    #1;
    push_exp(1, 14, 3); push_exp(1, 18, 1);
    tx_if.tready = 1'b1;
    drain(1'b0);

    // Oversized doorbell: sticky error, nothing issued.
    doorbell(2, 16'd265);
    for (int j = 0; j < 4; j++) begin
      @(negedge aclk);
      check("err_no_tx", tx_if.tvalid, 1'b0);
    end
    check("err_set", error, 1'b1);
    @(posedge aclk); #1;

    // Reset while a request is held.
    tx_if.tready = 1'b0;
    doorbell(0, 16'd13);
    @(negedge aclk); @(negedge aclk);
    check("pre_rst_tvalid", tx_if.tvalid, 1'b1);
    @(posedge aclk); #1;
    areset_n = 1'b0;
    @(negedge aclk);
    check("midrst_tvalid", tx_if.tvalid, 1'b0);
    check("midrst_error", error, 1'b0);
    @(posedge aclk); #1;
    areset_n = 1'b1;
    exp_q.delete();
    tx_if.tready = 1'b1;
    model_reset();
    @(posedge aclk); #1;

    // Random batches: first doorbell launches a request under stall, more
    // doorbells pile up, then everything drains in round-robin order.
    for (int b = 0; b < 40; b++) begin
      tx_if.tready = 1'b0;
      q  = $urandom_range(0, NQ - 1);
      ni = last_m[q] + 16'($urandom_range(1, 12));
      if ($urandom_range(0, 7) == 0) ni = last_m[q] + 16'(QS);
      doorbell(q, ni);
      model_notify(q, ni);
      void'(pick(fq, foff, flen));
      push_exp(fq, foff, flen - 1);
      ni = avail_m[q] + 16'($urandom_range(0, 6));
      doorbell(q, ni);
      model_notify(q, ni);
      k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) begin
        q2 = $urandom_range(0, NQ - 1);
        ni = avail_m[q2] + 16'($urandom_range(0, 10));
        if ($urandom_range(0, 9) == 0) ni = last_m[q2] + 16'(QS + $urandom_range(1, 50));
        doorbell(q2, ni);
        model_notify(q2, ni);
      end
      commit(fq, flen);
      while (pick(fq, foff, flen)) begin
        push_exp(fq, foff, flen - 1);
        commit(fq, flen);
      end
      drain(1'b1);
      check("rand_error", error, exp_error);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/virtio_available_ring_scheduler.md
# virtio_available_ring_scheduler

Round-robin scheduler that turns per-virtqueue available-index doorbells into REQUEST_READ_RING requests for the available ring reader path. It tracks the driver-published available index and the last-consumed index per queue, then issues bounded chunks on one AXI4-Stream request channel. The channel feeds the available ring monitor/reader.

## Interface
- QUEUES, 4: number of virtqueues served; power of 2, ≥2.
- QUEUE_SIZE, 256: ring entries per queue; power of 2, ≤32768.
- MAX_DESCRIPTOR_INDEXES, 4: maximum indexes per request; power of 2, ≤QUEUE_SIZE.
- QUEUE_WIDTH, $clog2(QUEUES): queue number width.

Ports:
- aclk  input  1  clock.
- areset_n  input  1  reset. Asynchronous, active-low. Clock is aclk.
- notify_valid  input  1  doorbell strobe.
- notify_queue  input  QUEUE_WIDTH  queue being notified.
- notify_index  input  16  new driver available index (free-running, mod 2^16).
- notify_ready  output  1  doorbell accepted. Low only while that queue is in reset (see Configuration).
- error  output  1  sticky: a doorbell implied more than QUEUE_SIZE pending entries.
- tx  logic_axi4_stream_if tx modport  request output.
  - tid = REQUEST_READ_RING.
  - tdata = request_t.
  - tdest = queue number.

## Operation
- Per-queue registers:
  - avail_idx[q], 16 bits.
  - last_idx[q], 16 bits.
  - All reset to 0.
- Doorbell: on notify_valid && notify_ready, compute diff = notify_index − last_idx[q] (16-bit wrap).
  - If diff ≤ QUEUE_SIZE: avail_idx[q] <= notify_index.
  - Otherwise: doorbell ignored and error <= 1. error clears only on reset.
- pending[q] = avail_idx[q] − last_idx[q], mod 2^16.
- Chunk length = min(pending, MAX_DESCRIPTOR_INDEXES, QUEUE_SIZE − (last_idx mod QUEUE_SIZE)). A request never crosses the ring wrap.
- request_t fields:
  - offset = last_idx mod QUEUE_SIZE.
  - length = chunk length − 1.
- State machine:
  - IDLE: if any pending[q] ≠ 0, grant the first such q scanning from ptr+1 (wrap), load tx, go to ISSUE.
  - ISSUE: hold tx.tvalid and all payload stable until tx.tready. On the handshake:
    - last_idx[q] += length+1;
    - ptr <= q;
    - re-arbitrate in the same cycle. Next grant goes to ISSUE; no pending request goes to IDLE.
- A doorbell to the granted queue during ISSUE updates avail_idx only. The in-flight payload is unchanged; the remainder is scheduled later.
- Queues with pending ≤ MAX drain in one request. Larger backlogs split; other queues are served between chunks.

## Timing
- Reset values:
  - tx.tvalid = 0;
  - error = 0;
  - notify_ready = 1;
  - ptr = QUEUES−1, so queue 0 has first priority;
  - state = IDLE.
  - tdata/tdest/tid are don't-care.
- Latency from a doorbell at cycle N (all idle) to tx.tvalid: cycle N+2, i.e. one cycle to register avail_idx and one to arbitrate and register tx.
- Back-to-back: with tx.tready held high, one request per cycle is sustained.
- Wrap: last_idx 0xFFFE, avail_idx 0x0002 gives pending 4.
- Reset mid-request drops the request silently; all indexes return to 0.

## Configuration
- VIRTIO_AVAILABLE_RING_SCHEDULER_QUEUE_RESET_EN
  - Defined: adds input queue_reset_valid (1) and input queue_reset_queue (QUEUE_WIDTH).
    - A pulse zeroes avail_idx/last_idx of that queue on the next edge.
    - notify_ready is low when notify_queue equals queue_reset_queue while queue_reset_valid is high.
    - If that queue is currently in ISSUE, its tx request completes unchanged, but last_idx is not advanced on the handshake.
  - Undefined: ports absent and notify_ready is constantly 1.

## Structure
- virtio_available_ring_pkg receives:
  - request_t and request_type_t (REQUEST_READ_RING, shared with the monitor);
  - a scheduler_state_t enum {IDLE, ISSUE}.
- One sub-module, virtio_available_ring_scheduler_arbiter: a combinational-plus-pointer round-robin arbiter with inputs request[QUEUES] and advance, and outputs grant_valid and grant index.

## Test plan
- Reset, then doorbell q0 index 3: tx at N+2 with tdest 0, offset 0, length 2. After the handshake, pending[0] = 0 and tvalid drops.
- Doorbell q1 index 10 (MAX 4): three requests with offset/length 0/3, 4/3, 8/1.
- q0 and q2 each with 8 pending, tready always high: tdest sequence 0, 2, 0, 2.
- QUEUE_SIZE 256, last_idx 254, doorbell index 260: requests offset 254 length 1, then offset 0 length 3.
- tready low for 5 cycles during ISSUE: tvalid, tdata and tdest stay stable; a doorbell to the same queue leaves the payload unchanged.
- Doorbell index last+QUEUE_SIZE+1: error = 1, avail_idx unchanged, no tx activity.
